// File: rtl/periph_slave_arbiter_pe.sv
// Slave-side arbiter: round-robin N_MASTER requests onto one peripheral, track granted IDs in order.
// Request path combinational; response 0-cycle (1-cycle with PERIPH_RESP_REG_EN). Stalls requests while ID FIFO is full.
module periph_slave_arbiter_pe #(
  parameter int N_MASTER        = 16,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH/8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_MASTER-1:0]                  data_req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
  input  logic [N_MASTER-1:0]                  data_wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
  input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
  input  logic [N_MASTER-1:0][ID_WIDTH-1:0]    data_ID_i,
  output logic [N_MASTER-1:0]                  data_gnt_o,
  output logic [N_MASTER-1:0]                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 data_r_opc_o,
  output logic                                 per_req_o,
  output logic [ADDR_WIDTH-1:0]                per_add_o,
  output logic                                 per_wen_o,
  output logic [DATA_WIDTH-1:0]                per_wdata_o,
  output logic [BE_WIDTH-1:0]                  per_be_o,
  input  logic                                 per_gnt_i,
  input  logic                                 per_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                per_r_rdata_i,
  input  logic                                 per_r_opc_i,
  output logic                                 spurious_resp_o
);

  localparam int PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int FP_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic             found;
  logic [PTR_W:0]   sum;
  logic             any_req;
  logic             handshake;
  logic             pop;
  logic             full;

  logic [ID_WIDTH-1:0] id_mem [MAX_OUTSTANDING];
  logic [FP_W-1:0]     rd_ptr;
  logic [FP_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [N_MASTER-1:0] resp_valid;

  function automatic logic [FP_W-1:0] fifo_next(input logic [FP_W-1:0] p);
    return (p == FP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan starting at rr_ptr; first requester found wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_MASTER))
        sum = sum - (PTR_W+1)'(N_MASTER);
      if (!found && data_req_i[sum[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[PTR_W-1:0];
      end
    end
  end

  assign any_req   = |data_req_i;
  assign pop       = per_r_valid_i && (count != '0);
  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  // A pop in the same cycle frees a slot, so a full FIFO only blocks without one.
  assign per_req_o = any_req && !(full && !pop);
  assign handshake = per_req_o && per_gnt_i;

  always_comb begin
    per_add_o   = '0;
    per_wen_o   = 1'b0;
    per_wdata_o = '0;
    per_be_o    = '0;
    data_gnt_o  = '0;
    if (any_req) begin
      per_add_o   = data_add_i[winner];
      per_wen_o   = data_wen_i[winner];
      per_wdata_o = data_wdata_i[winner];
      per_be_o    = data_be_i[winner];
    end
    if (handshake)
      data_gnt_o[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      spurious_resp_o <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= (winner == PTR_W'(N_MASTER - 1)) ? '0 : winner + 1'b1;
        wr_ptr <= fifo_next(wr_ptr);
      end
      if (pop)
        rd_ptr <= fifo_next(rd_ptr);
      if (handshake && !pop)
        count <= count + 1'b1;
      else if (pop && !handshake)
        count <= count - 1'b1;
      if (per_r_valid_i && (count == '0))
        spurious_resp_o <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (handshake)
      id_mem[wr_ptr] <= data_ID_i[winner];
  end

  assign resp_valid = pop ? N_MASTER'(id_mem[rd_ptr]) : '0;

`ifdef PERIPH_RESP_REG_EN
  logic [N_MASTER-1:0]   r_valid_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic                  r_opc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= '0;
      r_rdata_q <= '0;
      r_opc_q   <= 1'b0;
    end else begin
      r_valid_q <= resp_valid;
      if (per_r_valid_i) begin
        r_rdata_q <= per_r_rdata_i;
        r_opc_q   <= per_r_opc_i;
      end
    end
  end

  assign data_r_valid_o = r_valid_q;
  assign data_r_rdata_o = r_rdata_q;
  assign data_r_opc_o   = r_opc_q;
`else
  assign data_r_valid_o = resp_valid;
  assign data_r_rdata_o = per_r_rdata_i;
  assign data_r_opc_o   = per_r_opc_i;
`endif

endmodule

// File: doc/periph_slave_arbiter_pe.md
Name: periph_slave_arbiter_pe

Overview:
- Slave-side stage of the peripheral interconnect, directly downstream of the per-PE request/response block.
- Collects the per-slave request lines and one-hot IDs that each PE-side block drives for one peripheral, round-robin arbitrates them onto that peripheral, and tracks granted IDs in order.
- Routes each peripheral response back as the per-slave r_valid/r_rdata/r_opc that the PE-side response tree consumes.

Parameters:
- N_MASTER, 16, number of PE-side requesters.
- ID_WIDTH, N_MASTER, width of the one-hot requester ID.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- MAX_OUTSTANDING, 2, depth of the in-order ID FIFO. Must be 1..8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_req_i  in  N_MASTER  request, one bit per master.
- data_add_i  in  N_MASTER x ADDR_WIDTH  address per master.
- data_wen_i  in  N_MASTER  1 = read, 0 = write.
- data_wdata_i  in  N_MASTER x DATA_WIDTH  write data per master.
- data_be_i  in  N_MASTER x BE_WIDTH  byte enables per master.
- data_ID_i  in  N_MASTER x ID_WIDTH  one-hot ID per master.
- data_gnt_o  out  N_MASTER  grant per master.
- data_r_valid_o  out  N_MASTER  response valid, routed to the originating master.
- data_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters.
- data_r_opc_o  out  1  response error/opcode, broadcast to all masters.
- per_req_o  out  1  request to peripheral.
- per_add_o  out  ADDR_WIDTH  address to peripheral.
- per_wen_o  out  1  write enable to peripheral.
- per_wdata_o  out  DATA_WIDTH  write data to peripheral.
- per_be_o  out  BE_WIDTH  byte enables to peripheral.
- per_gnt_i  in  1  grant from peripheral.
- per_r_valid_i  in  1  response valid from peripheral.
- per_r_rdata_i  in  DATA_WIDTH  response data from peripheral.
- per_r_opc_i  in  1  response opcode from peripheral.
- spurious_resp_o  out  1  sticky flag: response received with ID FIFO empty.

Behaviour:
- Reset values: rr_ptr = 0, FIFO empty, spurious_resp_o = 0.
- Request path is combinational. Winner = first requesting master at or after rr_ptr, wrapping modulo N_MASTER.
- per_req_o = |data_req_i && !fifo_full_blocked. fifo_full_blocked = full && !(pop this cycle).
- per_add_o, per_wen_o, per_wdata_o, per_be_o = fields of the winner. All zero when no request.
- data_gnt_o[winner] = per_gnt_i && per_req_o. All other grants = 0.
- Handshake = per_req_o && per_gnt_i. On handshake:
  - rr_ptr <= (winner + 1) mod N_MASTER.
  - Push data_ID_i[winner] into the ID FIFO.
- Without a handshake rr_ptr holds. A requester must hold req/fields until granted; the arbiter may change winner between cycles only if a higher-priority request arrives.
- Peripheral responds in order, no earlier than the cycle after the handshake.
- On per_r_valid_i with FIFO non-empty:
  - Pop the FIFO.
  - data_r_valid_o = popped one-hot ID, same cycle (0 latency on the response path).
  - data_r_rdata_o = per_r_rdata_i, data_r_opc_o = per_r_opc_i.
- Simultaneous push and pop: allowed, including when full; occupancy unchanged.
- Full and no pop: per_req_o = 0, all grants 0.
- per_r_valid_i with FIFO empty: no data_r_valid_o bit set; spurious_resp_o <= 1, cleared only by reset.
- FIFO is a circular buffer with wrapping rd/wr pointers plus a count of width $clog2(MAX_OUTSTANDING+1).
- An ID other than one-hot is forwarded unchanged; no checking.
- Reset mid-transaction: outstanding IDs are discarded; later responses count as spurious. This is the system's responsibility.

Optional Feature:
- Macro PERIPH_RESP_REG_EN.
- Defined: response path registered.
  - data_r_valid_o, data_r_rdata_o, data_r_opc_o are driven from flops one cycle after per_r_valid_i.
  - Flops reset to 0; rdata flop updates only on valid.
  - FIFO pop still occurs in the per_r_valid_i cycle, so occupancy timing is unchanged.
- Undefined: combinational response as described above.

Test Plan:
- Single read, master 3 (ID 16'h0008): req with gnt=1 -> per_req_o=1, data_gnt_o=16'h0008. Response rdata=32'hDEADBEEF next cycle -> data_r_valid_o=16'h0008, data_r_rdata_o=32'hDEADBEEF (one cycle later with PERIPH_RESP_REG_EN).
- Masters 0 and 5 both requesting continuously, gnt=1, immediate responses -> grants alternate 0,5,0,5. rr_ptr after the first grant = 1.
- MAX_OUTSTANDING=2, peripheral grants but withholds responses -> two grants, then per_req_o=0 and data_gnt_o=0. The first response re-enables grant in that same cycle.
- per_gnt_i=0 for 4 cycles with master 7 requesting -> per_add_o stable, data_gnt_o=0, FIFO count 0, rr_ptr unchanged.
- per_r_valid_i=1 with FIFO empty -> data_r_valid_o=0, spurious_resp_o=1 and stays high until rst_n low.
- rst_n asserted low with 2 outstanding -> count=0, rr_ptr=0, all outputs 0 asynchronously.
